// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: word addresses, exception codes,
// MEM-stage control ops and the run/halt state.
package pipeline_ctrl_pkg;

  localparam int WORD_ADDR_W = 30;
  typedef logic [WORD_ADDR_W-1:0] word_addr_t;

  typedef enum logic [2:0] {
    ISA_EXP_NO_EXP     = 3'd0,
    ISA_EXP_EXT_INT    = 3'd1,
    ISA_EXP_UNDEF_INSN = 3'd2,
    ISA_EXP_OVERFLOW   = 3'd3,
    ISA_EXP_MISS_ALIGN = 3'd4,
    ISA_EXP_TRAP       = 3'd5,
    ISA_EXP_PRV_VIO    = 3'd6
  } isa_exp_t;

  typedef enum logic [2:0] {
    CTRL_OP_NOP  = 3'd0,
    CTRL_OP_HALT = 3'd1,
    CTRL_OP_ERET = 3'd2,
    CTRL_OP_EI   = 3'd3,
    CTRL_OP_DI   = 3'd4
  } ctrl_op_t;

  typedef enum logic {
    CPU_RUN  = 1'b0,
    CPU_HALT = 1'b1
  } cpu_state_t;

  localparam logic DISABLE = 1'b0;
  localparam logic ENABLE  = 1'b1;

  // Next word address; wraps modulo 2^WORD_ADDR_W.
  function automatic word_addr_t word_inc(input word_addr_t a);
    return a + word_addr_t'(1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush control into one pipeline register; the controller is the master.
interface pipeline_io;
  logic stall;
  logic flush;

  modport master (output stall, output flush);
  modport slave  (input stall, input flush);
endinterface

// File: rtl/pipeline_ctrl_exp_regs.sv
// Exception state registers (EPC, cause, interrupt enable) with per-field
// write enables driven by the commit logic.
module pipeline_ctrl_exp_regs
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       epc_we,
  input  word_addr_t epc_d,
  input  logic       cause_we,
  input  isa_exp_t   cause_d,
  input  logic       int_en_we,
  input  logic       int_en_d,
  output word_addr_t epc,
  output isa_exp_t   exp_cause,
  output logic       int_en
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc       <= '0;
      exp_cause <= ISA_EXP_NO_EXP;
      int_en    <= DISABLE;
    end else begin
      if (epc_we)    epc       <= epc_d;
      if (cause_we)  exp_cause <= cause_d;
      if (int_en_we) int_en    <= int_en_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall/flush generation, MEM-stage commit of
// exceptions/ERET/IRQ/HALT/EI/DI, fetch redirect and the run/halt FSM.
//
// state    | meaning
// CPU_RUN  | normal flow; commit events evaluated at MEM
// CPU_HALT | whole pipeline frozen until an enabled interrupt arrives
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter word_addr_t EXP_VECTOR = '0
) (
  input  logic       clk,
  input  logic       rst,
  pipeline_io.master if_pl,
  pipeline_io.master id_pl,
  pipeline_io.master ex_pl,
  pipeline_io.master mem_pl,
  input  logic       if_busy,
  input  logic       mem_busy,
  input  logic       ld_hazard,
  input  word_addr_t mem_pc,
  input  logic       mem_en,
  input  ctrl_op_t   mem_ctrl_op,
  input  isa_exp_t   mem_exp_code,
  input  logic       irq,
  output word_addr_t new_pc,
  output word_addr_t epc,
  output isa_exp_t   exp_cause,
  output logic       int_en
);

  cpu_state_t state, state_nx;

  // Bit order for stall_v/flush_v: [3]=IF [2]=ID [1]=EX [0]=MEM.
  logic [3:0] stall_v, flush_v;
  logic       bus_stall, irq_req;
  logic       epc_we, cause_we, int_en_we, int_en_d;
  word_addr_t epc_d;
  isa_exp_t   cause_d;

  assign bus_stall = if_busy | mem_busy;
  assign irq_req   = irq & int_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CPU_RUN;
    else      state <= state_nx;
  end

  always_comb begin
    stall_v   = '0;
    flush_v   = '0;
    new_pc    = '0;
    state_nx  = state;
    epc_we    = 1'b0;
    epc_d     = mem_pc;
    cause_we  = 1'b0;
    cause_d   = ISA_EXP_NO_EXP;
    int_en_we = 1'b0;
    int_en_d  = DISABLE;

    if (!rst) begin
      state_nx = CPU_RUN;
    end else if (state == CPU_HALT) begin
      // The halted MEM instruction is retired, so resume after it.
      if (!bus_stall && irq_req) begin
        flush_v   = '1;
        new_pc    = EXP_VECTOR;
        epc_we    = 1'b1;
        epc_d     = word_inc(mem_pc);
        cause_we  = 1'b1;
        cause_d   = ISA_EXP_EXT_INT;
        int_en_we = 1'b1;
        state_nx  = CPU_RUN;
      end else begin
        stall_v = '1;
      end
    end else if (bus_stall) begin
      // Flushes are held back: the slaves ignore them while stalled.
      stall_v = '1;
    end else if (mem_en && (mem_exp_code != ISA_EXP_NO_EXP)) begin
      flush_v   = '1;
      new_pc    = EXP_VECTOR;
      epc_we    = 1'b1;
      cause_we  = 1'b1;
      cause_d   = mem_exp_code;
      int_en_we = 1'b1;
    end else if (mem_en && (mem_ctrl_op == CTRL_OP_ERET)) begin
      flush_v   = '1;
      new_pc    = epc;
      int_en_we = 1'b1;
      int_en_d  = ENABLE;
    end else if (mem_en && irq_req) begin
      // EPC points at the MEM instruction so it is re-executed on return.
      flush_v   = '1;
      new_pc    = EXP_VECTOR;
      epc_we    = 1'b1;
      cause_we  = 1'b1;
      cause_d   = ISA_EXP_EXT_INT;
      int_en_we = 1'b1;
    end else if (mem_en && (mem_ctrl_op == CTRL_OP_HALT)) begin
      flush_v  = 4'b1110;
      state_nx = CPU_HALT;
    end else begin
      if (mem_en && (mem_ctrl_op == CTRL_OP_EI)) begin
        int_en_we = 1'b1;
        int_en_d  = ENABLE;
      end else if (mem_en && (mem_ctrl_op == CTRL_OP_DI)) begin
        int_en_we = 1'b1;
      end
      if (ld_hazard) begin
        stall_v[3] = 1'b1;
        flush_v[2] = 1'b1;
      end
    end
  end

  assign if_pl.stall  = stall_v[3];
  assign id_pl.stall  = stall_v[2];
  assign ex_pl.stall  = stall_v[1];
  assign mem_pl.stall = stall_v[0];
  assign if_pl.flush  = flush_v[3];
  assign id_pl.flush  = flush_v[2];
  assign ex_pl.flush  = flush_v[1];
  assign mem_pl.flush = flush_v[0];

  pipeline_ctrl_exp_regs u_exp_regs (
    .clk       (clk),
    .rst       (rst),
    .epc_we    (epc_we),
    .epc_d     (epc_d),
    .cause_we  (cause_we),
    .cause_d   (cause_d),
    .int_en_we (int_en_we),
    .int_en_d  (int_en_d),
    .epc       (epc),
    .exp_cause (exp_cause),
    .int_en    (int_en)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each step pushes its expected outputs to
// a scoreboard queue, which is popped and compared mid-cycle.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam word_addr_t VEC = 30'h100;

  logic       clk, rst;
  logic       if_busy, mem_busy, ld_hazard, mem_en, irq;
  word_addr_t mem_pc, new_pc, epc;
  ctrl_op_t   mem_ctrl_op;
  isa_exp_t   mem_exp_code, exp_cause;
  logic       int_en;

  pipeline_io if_io ();
  pipeline_io id_io ();
  pipeline_io ex_io ();
  pipeline_io mem_io ();

  pipeline_ctrl #(.EXP_VECTOR(VEC)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_pl        (if_io),
    .id_pl        (id_io),
    .ex_pl        (ex_io),
    .mem_pl       (mem_io),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .ld_hazard    (ld_hazard),
    .mem_pc       (mem_pc),
    .mem_en       (mem_en),
    .mem_ctrl_op  (mem_ctrl_op),
    .mem_exp_code (mem_exp_code),
    .irq          (irq),
    .new_pc       (new_pc),
    .epc          (epc),
    .exp_cause    (exp_cause),
    .int_en       (int_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] stall;
    logic [3:0] flush;
    word_addr_t npc;
    logic       chk_npc;
    word_addr_t epc;
    isa_exp_t   cause;
    logic       ie;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic drive(input logic ib, input logic mb, input logic ld, input logic en,
                       input word_addr_t pc, input ctrl_op_t op, input isa_exp_t code,
                       input logic iq);
    if_busy      = ib;
    mem_busy     = mb;
    ld_hazard    = ld;
    mem_en       = en;
    mem_pc       = pc;
    mem_ctrl_op  = op;
    mem_exp_code = code;
    irq          = iq;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] st, input logic [3:0] fl,
                            input word_addr_t npc, input logic chk_npc, input word_addr_t e_epc,
                            input isa_exp_t cause, input logic ie);
    exp_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.npc = npc; e.chk_npc = chk_npc;
    e.epc = e_epc; e.cause = cause; e.ie = ie;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [3:0] st, fl;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d want=>0", sb.size());
    end
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      st = {if_io.stall, id_io.stall, ex_io.stall, mem_io.stall};
      fl = {if_io.flush, id_io.flush, ex_io.flush, mem_io.flush};
      total++;
      assert (st === e.stall) else begin
        bad++; $error("FAIL %s.stall got=%b want=%b", e.tag, st, e.stall);
      end
      total++;
      assert (fl === e.flush) else begin
        bad++; $error("FAIL %s.flush got=%b want=%b", e.tag, fl, e.flush);
      end
      if (e.chk_npc) begin
        total++;
        assert (new_pc === e.npc) else begin
          bad++; $error("FAIL %s.new_pc got=%h want=%h", e.tag, new_pc, e.npc);
        end
      end
      total++;
      assert (epc === e.epc) else begin
        bad++; $error("FAIL %s.epc got=%h want=%h", e.tag, epc, e.epc);
      end
      total++;
      assert (exp_cause === e.cause) else begin
        bad++; $error("FAIL %s.cause got=%0d want=%0d", e.tag, exp_cause, e.cause);
      end
      total++;
      assert (int_en === e.ie) else begin
        bad++; $error("FAIL %s.int_en got=%b want=%b", e.tag, int_en, e.ie);
      end
    end
  endtask

  // Inputs are already driven at posedge+2; compare at posedge+4, then advance.
  task automatic run(input string tag, input logic [3:0] st, input logic [3:0] fl,
                     input word_addr_t npc, input logic chk_npc, input word_addr_t e_epc,
                     input isa_exp_t cause, input logic ie);
    expect_out(tag, st, fl, npc, chk_npc, e_epc, cause, ie);
    #2;
    check();
    @(posedge clk);
    #2;
  endtask

  localparam ctrl_op_t NOP  = CTRL_OP_NOP;
  localparam isa_exp_t NOEX = ISA_EXP_NO_EXP;

  initial begin
    rst = 1'b0;
    drive(1, 1, 1, 1, 30'h40, CTRL_OP_ERET, ISA_EXP_OVERFLOW, 1);
    @(posedge clk); #2;
    run("in_reset", 4'b0000, 4'b0000, 30'h0, 1, 30'h0, NOEX, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 30'h0, NOP, NOEX, 0);
    run("idle", 4'b0000, 4'b0000, 30'h0, 1, 30'h0, NOEX, 0);

    drive(0, 0, 1, 0, 30'h0, NOP, NOEX, 0);
    run("ld_use", 4'b1000, 4'b0100, 30'h0, 1, 30'h0, NOEX, 0);
    drive(1, 0, 1, 0, 30'h0, NOP, NOEX, 0);
    run("ld_busy", 4'b1111, 4'b0000, 30'h0, 1, 30'h0, NOEX, 0);

    drive(0, 0, 0, 1, 30'h40, NOP, ISA_EXP_OVERFLOW, 0);
    run("exp_ovf", 4'b0000, 4'b1111, VEC, 1, 30'h0, NOEX, 0);
    drive(0, 0, 0, 0, 30'h0, NOP, NOEX, 0);
    run("exp_ovf_regs", 4'b0000, 4'b0000, 30'h0, 1, 30'h40, ISA_EXP_OVERFLOW, 0);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 30'h44, NOP, ISA_EXP_UNDEF_INSN, 0);
      run("exp_deferred", 4'b1111, 4'b0000, 30'h0, 1, 30'h40, ISA_EXP_OVERFLOW, 0);
    end
    drive(0, 0, 0, 1, 30'h44, NOP, ISA_EXP_UNDEF_INSN, 0);
    run("exp_release", 4'b0000, 4'b1111, VEC, 1, 30'h40, ISA_EXP_OVERFLOW, 0);

    drive(0, 0, 1, 1, 30'h50, NOP, ISA_EXP_OVERFLOW, 0);
    run("exp_vs_ld", 4'b0000, 4'b1111, VEC, 1, 30'h44, ISA_EXP_UNDEF_INSN, 0);

    drive(0, 0, 0, 1, 30'h60, CTRL_OP_EI, NOEX, 0);
    run("ei", 4'b0000, 4'b0000, 30'h0, 1, 30'h50, ISA_EXP_OVERFLOW, 0);
    drive(0, 0, 0, 1, 30'h80, NOP, NOEX, 1);
    run("irq", 4'b0000, 4'b1111, VEC, 1, 30'h50, ISA_EXP_OVERFLOW, 1);
    drive(0, 0, 0, 1, 30'h100, CTRL_OP_ERET, NOEX, 0);
    run("eret", 4'b0000, 4'b1111, 30'h80, 1, 30'h80, ISA_EXP_EXT_INT, 0);
    drive(0, 0, 0, 1, 30'h81, CTRL_OP_DI, NOEX, 0);
    run("di", 4'b0000, 4'b0000, 30'h0, 1, 30'h80, ISA_EXP_EXT_INT, 1);
    drive(0, 0, 0, 1, 30'h90, CTRL_OP_ERET, ISA_EXP_TRAP, 1);
    run("exp_over_eret", 4'b0000, 4'b1111, VEC, 1, 30'h80, ISA_EXP_EXT_INT, 0);

    drive(0, 0, 0, 1, 30'h10, CTRL_OP_HALT, NOEX, 0);
    run("halt", 4'b0000, 4'b1110, 30'h0, 0, 30'h90, ISA_EXP_TRAP, 0);
    drive(0, 0, 0, 1, 30'h10, CTRL_OP_HALT, NOEX, 0);
    run("halted", 4'b1111, 4'b0000, 30'h0, 1, 30'h90, ISA_EXP_TRAP, 0);
    drive(0, 0, 0, 1, 30'h10, CTRL_OP_HALT, NOEX, 1);
    run("halt_irq_masked", 4'b1111, 4'b0000, 30'h0, 1, 30'h90, ISA_EXP_TRAP, 0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 30'h0, NOP, NOEX, 0);
    expect_out("reset_mid_halt", 4'b0000, 4'b0000, 30'h0, 1, 30'h0, NOEX, 0);
    #1;
    check();
    @(posedge clk); #2;
    rst = 1'b1;
    run("after_reset", 4'b0000, 4'b0000, 30'h0, 1, 30'h0, NOEX, 0);

    drive(0, 0, 0, 1, 30'h20, CTRL_OP_EI, NOEX, 0);
    run("ei2", 4'b0000, 4'b0000, 30'h0, 1, 30'h0, NOEX, 0);
    drive(0, 0, 0, 1, 30'h10, CTRL_OP_HALT, NOEX, 0);
    run("halt2", 4'b0000, 4'b1110, 30'h0, 0, 30'h0, NOEX, 1);
    drive(0, 0, 0, 1, 30'h10, CTRL_OP_HALT, NOEX, 0);
    run("halted2", 4'b1111, 4'b0000, 30'h0, 1, 30'h0, NOEX, 1);
    drive(0, 0, 0, 1, 30'h10, CTRL_OP_HALT, NOEX, 1);
    run("wake", 4'b0000, 4'b1111, VEC, 1, 30'h0, NOEX, 1);
    drive(0, 0, 0, 0, 30'h0, NOP, NOEX, 0);
    run("wake_regs", 4'b0000, 4'b0000, 30'h0, 1, 30'h11, ISA_EXP_EXT_INT, 0);

    drive(0, 0, 0, 1, 30'h30, CTRL_OP_EI, NOEX, 0);
    run("ei3", 4'b0000, 4'b0000, 30'h0, 1, 30'h11, ISA_EXP_EXT_INT, 0);
    drive(0, 0, 0, 1, 30'h3FFF_FFFF, CTRL_OP_HALT, NOEX, 0);
    run("halt_top", 4'b0000, 4'b1110, 30'h0, 0, 30'h11, ISA_EXP_EXT_INT, 1);
    drive(0, 0, 0, 1, 30'h3FFF_FFFF, CTRL_OP_HALT, NOEX, 1);
    run("wake_top", 4'b0000, 4'b1111, VEC, 1, 30'h11, ISA_EXP_EXT_INT, 1);
    drive(0, 0, 0, 0, 30'h0, NOP, NOEX, 0);
    run("wrap_regs", 4'b0000, 4'b0000, 30'h0, 1, 30'h0, ISA_EXP_EXT_INT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
